// File: rtl/tournament_update_scheduler.sv
// tournament_update_scheduler
//
// Queues resolved branches and feeds them to the global/choice predictor
// tables. Each table update uses a two-cycle slot: a read cycle, then a write
// cycle. The index and outcome stay constant for the whole slot. The block
// also keeps the global path-history register that the table index is
// built from.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        asynchronous active-high reset, clears all state
//   res_valid    resolved branch presented
//   res_ph       path history the branch was predicted with
//   res_taken    actual branch outcome
//   res_mispred  branch was mispredicted (qualified by res_valid)
//   res_ready    queue can accept (q_count < QDEPTH)
//   tbl_en       slot active
//   tbl_phase    0 = read cycle, 1 = write cycle of the slot
//   tbl_ph       table index for the current slot
//   tbl_taken    outcome for the current slot
//   ghist        current global path history
//   q_count      number of entries held in the queue
//   busy         slot in progress or queue not empty
//   mispred_cnt  saturating count of accepted mispredicts
module tournament_update_scheduler #(
    parameter int PH_W   = 12,
    parameter int QDEPTH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        res_valid,
    input  logic [PH_W-1:0]             res_ph,
    input  logic                        res_taken,
    input  logic                        res_mispred,
    output logic                        res_ready,
    output logic                        tbl_en,
    output logic                        tbl_phase,
    output logic [PH_W-1:0]             tbl_ph,
    output logic                        tbl_taken,
    output logic [PH_W-1:0]             ghist,
    output logic [$clog2(QDEPTH):0]     q_count,
    output logic                        busy,
    output logic [CNT_W-1:0]            mispred_cnt
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [PH_W:0]     mem [QDEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     q_count_reg;
    logic [PH_W-1:0]   ghist_reg;
    logic [CNT_W-1:0]  mispred_cnt_reg;
    logic              tbl_en_reg;
    logic              tbl_phase_reg;
    logic [PH_W-1:0]   tbl_ph_reg;
    logic              tbl_taken_reg;
    logic              push;
    logic              pop;

    // A push never bypasses to a pop on the same edge. A pop only happens
    // when the queue was already non-empty before that edge.
    assign res_ready = (q_count_reg < CW'(QDEPTH));
    assign push      = res_valid && res_ready;
    assign pop       = (state_reg != READ) && (q_count_reg != '0);

    assign q_count     = q_count_reg;
    assign ghist       = ghist_reg;
    assign mispred_cnt = mispred_cnt_reg;
    assign tbl_en      = tbl_en_reg;
    assign tbl_phase   = tbl_phase_reg;
    assign tbl_ph      = tbl_ph_reg;
    assign tbl_taken   = tbl_taken_reg;
    assign busy        = (state_reg != IDLE) || (q_count_reg != '0);

    // Queue storage has no reset. q_count alone decides which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= {res_ph, res_taken};
        end
    end

    // Queue pointers, occupancy, path history and statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            q_count_reg     <= '0;
            ghist_reg       <= '0;
            mispred_cnt_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   q_count_reg <= q_count_reg + CW'(1);
                2'b01:   q_count_reg <= q_count_reg - CW'(1);
                default: q_count_reg <= q_count_reg;
            endcase
            if (push) begin
                // A mispredict repairs history from the branch's own snapshot.
                if (res_mispred) begin
                    ghist_reg <= {res_ph[PH_W-2:0], res_taken};
                end else begin
                    ghist_reg <= {ghist_reg[PH_W-2:0], res_taken};
                end
                if (res_mispred && (mispred_cnt_reg != '1)) begin
                    mispred_cnt_reg <= mispred_cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    // Slot FSM. The head entry is captured only on entry to READ, so the
    // index and outcome stay the same through the whole slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            tbl_en_reg    <= 1'b0;
            tbl_phase_reg <= 1'b0;
            tbl_ph_reg    <= '0;
            tbl_taken_reg <= 1'b0;
        end else begin
            case (state_reg)
                READ: begin
                    state_reg     <= WRITE;
                    tbl_en_reg    <= 1'b1;
                    tbl_phase_reg <= 1'b1;
                end
                default: begin
                    if (pop) begin
                        state_reg     <= READ;
                        tbl_en_reg    <= 1'b1;
                        tbl_phase_reg <= 1'b0;
                        tbl_ph_reg    <= mem[rd_ptr_reg][PH_W:1];
                        tbl_taken_reg <= mem[rd_ptr_reg][0];
                    end else begin
                        state_reg     <= IDLE;
                        tbl_en_reg    <= 1'b0;
                        tbl_phase_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tournament_update_scheduler.sv
// Testbench for tournament_update_scheduler. A scoreboard queue holds the
// accepted branches. Each slot that issues pops one entry and compares it.
module tb_tournament_update_scheduler;

    localparam int PH_W   = 12;
    localparam int QDEPTH = 4;
    localparam int CNT_W  = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              res_valid;
    logic [PH_W-1:0]   res_ph;
    logic              res_taken;
    logic              res_mispred;
    logic              res_ready;
    logic              tbl_en;
    logic              tbl_phase;
    logic [PH_W-1:0]   tbl_ph;
    logic              tbl_taken;
    logic [PH_W-1:0]   ghist;
    logic [2:0]        q_count;
    logic              busy;
    logic [CNT_W-1:0]  mispred_cnt;

    tournament_update_scheduler #(
        .PH_W(PH_W), .QDEPTH(QDEPTH), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset(reset),
        .res_valid(res_valid), .res_ph(res_ph), .res_taken(res_taken),
        .res_mispred(res_mispred), .res_ready(res_ready),
        .tbl_en(tbl_en), .tbl_phase(tbl_phase), .tbl_ph(tbl_ph),
        .tbl_taken(tbl_taken), .ghist(ghist), .q_count(q_count),
        .busy(busy), .mispred_cnt(mispred_cnt)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [PH_W-1:0] ph;
        logic            t;
    } ent_t;

    int              checks = 0;
    int              errors = 0;
    ent_t            sb[$];
    ent_t            cur;
    int              m_count;
    int              m_state;      // 0 idle, 1 read, 2 write
    logic [PH_W-1:0] m_ghist;
    int              m_mis;
    int              issued;
    bit              saw_full;
    int              max_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_state = 0;
        m_ghist = '0;
        m_mis   = 0;
    endtask

    task automatic drive(input bit v, input logic [PH_W-1:0] ph, input bit t, input bit m);
        res_valid   = v;
        res_ph      = ph;
        res_taken   = t;
        res_mispred = m;
    endtask

    // One clock: predict accept/pop, advance the model, then check outputs
    // 1 time unit after the edge.
    task automatic step(output bit acc);
        bit pop;
        check("res_ready", res_ready, m_count < QDEPTH);
        acc = res_valid && (m_count < QDEPTH);
        pop = (m_state != 1) && (m_count != 0);
        @(posedge clock);
        if (pop) begin
            cur = sb.pop_front();
            issued++;
            $display("issue   ph=%h taken=%b", cur.ph, cur.t);
        end
        if (acc) begin
            sb.push_back({res_ph, res_taken});
            if (res_mispred) begin
                m_ghist = {res_ph[PH_W-2:0], res_taken};
                if (m_mis < 15) m_mis++;
            end else begin
                m_ghist = {m_ghist[PH_W-2:0], res_taken};
            end
            $display("accept  ph=%h taken=%b mispred=%b", res_ph, res_taken, res_mispred);
        end
        m_state = pop ? 1 : ((m_state == 1) ? 2 : 0);
        m_count = m_count + int'(acc) - int'(pop);
        if (m_count == QDEPTH) saw_full = 1;
        if (m_count > max_count) max_count = m_count;
        #1;
        check("tbl_en", tbl_en, m_state != 0);
        check("tbl_phase", tbl_phase, m_state == 2);
        check("q_count", q_count, m_count);
        check("ghist", ghist, m_ghist);
        check("mispred_cnt", mispred_cnt, m_mis);
        check("busy", busy, (m_state != 0) || (m_count != 0));
        if (m_state != 0) begin
            check("tbl_ph", tbl_ph, cur.ph);
            check("tbl_taken", tbl_taken, cur.t);
        end
    endtask

    task automatic drain(input int budget);
        bit a;
        int k = 0;
        drive(0, '0, 0, 0);
        while ((m_state != 0 || m_count != 0) && k < budget) begin
            step(a);
            k++;
        end
        check("drain_timeout", (m_state != 0 || m_count != 0), 0);
    endtask

    // Called 1 unit after an edge. Reset is pulsed between clock edges.
    task automatic do_reset();
        drive(0, '0, 0, 0);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        model_reset();
    endtask

    task automatic single_slot(input string pfx);
        bit a;
        drive(1, 12'h0A5, 1, 0);
        step(a);
        drive(0, '0, 0, 0);
        step(a);
        check({pfx, "_read_en"}, {tbl_en, tbl_phase}, 2'b10);
        check({pfx, "_read_ph"}, tbl_ph, 12'h0A5);
        step(a);
        check({pfx, "_write_en"}, {tbl_en, tbl_phase}, 2'b11);
        check({pfx, "_write_ph"}, tbl_ph, 12'h0A5);
        check({pfx, "_taken"}, tbl_taken, 1);
        step(a);
        check({pfx, "_idle"}, tbl_en, 0);
        check({pfx, "_ghist"}, ghist, 12'h001);
    endtask

    initial begin
        bit a;
        int n;
        int cyc;
        int base;
        reset = 1'b1;
        drive(0, '0, 0, 0);
        model_reset();
        issued = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_tbl_en", tbl_en, 0);
        check("rst_tbl_phase", tbl_phase, 0);
        check("rst_tbl_ph", tbl_ph, 0);
        check("rst_tbl_taken", tbl_taken, 0);
        check("rst_ghist", ghist, 0);
        check("rst_q_count", q_count, 0);
        check("rst_busy", busy, 0);
        check("rst_mispred", mispred_cnt, 0);
        check("rst_ready", res_ready, 1);
        reset = 1'b0;

        // Single update, fixed latency
        single_slot("t1");

        // Burst of 10 accepts: fill, back-pressure, back-to-back in-order slots
        do_reset();
        saw_full = 0;
        max_count = 0;
        base = issued;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 100) begin
            drive(1, PH_W'(12'h100 + n), n[0], 0);
            step(a);
            if (a) n++;
            cyc++;
        end
        drain(50);
        check("t2_full_seen", saw_full, 1);
        check("t2_max_count", max_count, QDEPTH);
        check("t2_issued", issued - base, 10);
        check("t2_sb_empty", sb.size(), 0);

        // Mispredict repairs history
        do_reset();
        drive(1, 12'hF0F, 0, 1);
        step(a);
        check("t3_ghist", ghist, 12'hE1E);
        check("t3_mispred", mispred_cnt, 1);
        drain(20);

        // Saturating mispredict count
        do_reset();
        n = 0;
        cyc = 0;
        while (n < 20 && cyc < 200) begin
            drive(1, PH_W'($urandom), 1'($urandom), 1);
            step(a);
            if (a) n++;
            cyc++;
        end
        drain(50);
        check("t4_saturate", mispred_cnt, 15);

        // Async reset in the middle of a WRITE cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, PH_W'(12'h300 + i), 1'(i), 0);
            step(a);
        end
        drive(0, '0, 0, 0);
        cyc = 0;
        while (m_state != 2 && cyc < 10) begin
            step(a);
            cyc++;
        end
        check("t5_in_write", m_state, 2);
        #2 reset = 1'b1;
        #1;
        check("t5_async_en", tbl_en, 0);
        check("t5_async_q", q_count, 0);
        check("t5_async_busy", busy, 0);
        #1 reset = 1'b0;
        model_reset();
        single_slot("t5");

        // Accept on the edge that leaves WRITE with an empty queue
        do_reset();
        drive(1, 12'h6AA, 0, 0);
        step(a);
        drive(0, '0, 0, 0);
        step(a);
        step(a);
        check("t6_write", {tbl_en, tbl_phase}, 2'b11);
        drive(1, 12'h6BB, 1, 0);
        step(a);
        check("t6_idle", tbl_en, 0);
        check("t6_q1", q_count, 1);
        drive(0, '0, 0, 0);
        step(a);
        check("t6_read", {tbl_en, tbl_phase}, 2'b10);
        check("t6_read_ph", tbl_ph, 12'h6BB);
        drain(20);
        // Four back-to-back accepts: push+pop at q_count = 2 leaves it at 2
        for (int i = 0; i < 4; i++) begin
            drive(1, PH_W'(12'h700 + i), 1'(i), 0);
            step(a);
            case (i)
                0: check("t6_cnt0", q_count, 1);
                1: check("t6_cnt1", q_count, 1);
                2: check("t6_cnt2", q_count, 2);
                default: check("t6_cnt3", q_count, 2);
            endcase
        end
        drain(30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
